// File: rtl/bit_serializer_if.sv
// Handshake and serial-output bundle for bit_serializer.
// master: the word source / observer side; slave: the serializer itself.
interface bit_serializer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic [CNT_W-1:0] word_cnt;

    modport master (
        output din, din_valid,
        input  din_ready, out, out_valid, busy, word_cnt
    );

    modport slave (
        input  din, din_valid,
        output din_ready, out, out_valid, busy, word_cnt
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end. Words arrive over a valid/ready handshake
// into a one-entry holding register, then shift out one bit per clock.
// The holding register lets the next word load the shift register on the
// edge that ends the current word's last bit, so streams have no gaps.
module bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b1,
    parameter int   CNT_W     = 16
) (
    input logic             clk,
    input logic             rst,
    bit_serializer_if.slave bus
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hr;
    logic             hr_full;
    logic [WIDTH-1:0] sr;
    logic [BW-1:0]    bcnt;
    logic [CNT_W-1:0] word_cnt;

    logic             accept;
    logic [WIDTH-1:0] sr_shifted;
    logic             head_bit;

    // rst is excluded here because the reset branch of the FSM has priority
    assign accept = bus.din_valid && !hr_full;

    // Shift toward whichever end feeds the output, zero filling behind
    always_comb begin
        sr_shifted = '0;
        if (MSB_FIRST != 0) begin
            sr_shifted = {sr[WIDTH-2:0], 1'b0};
        end else begin
            sr_shifted = {1'b0, sr[WIDTH-1:1]};
        end
    end

    assign head_bit = (MSB_FIRST != 0) ? sr[WIDTH-1] : sr[0];

    // Outputs are selected from flop values only; no path from din/rst to out
    assign bus.out       = (state == SHIFT) ? head_bit : IDLE_BIT;
    assign bus.out_valid = (state == SHIFT);
    assign bus.busy      = (state == SHIFT) || hr_full;
    assign bus.din_ready = !hr_full && !rst;
    assign bus.word_cnt  = word_cnt;

    // Holding-register capture plus IDLE/SHIFT sequencing of the shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hr       <= '0;
            hr_full  <= 1'b0;
            sr       <= '0;
            bcnt     <= '0;
            word_cnt <= '0;
        end else begin
            // Accept needs hr_full = 0 and a transfer needs hr_full = 1,
            // so the two hr_full writes below never coincide.
            if (accept) begin
                hr      <= bus.din;
                hr_full <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (hr_full) begin
                        sr      <= hr;
                        hr_full <= 1'b0;
                        bcnt    <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr   <= sr_shifted;
                    bcnt <= bcnt + 1'b1;
                    if (bcnt == LAST_BIT) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (hr_full) begin
                            sr      <= hr;
                            hr_full <= 1'b0;
                            bcnt    <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
